// File: rtl/q_update_engine.sv
// Q-learning update stage: owns the Q-table, applies one Bellman update per request
// over a fixed FETCH/MAX/TARGET/WRITE/DONE sequence, and serves a registered policy read row.
//
// state  | meaning
// IDLE   | wait for start; latch request or flag a malformed action
// FETCH  | register rows for s and s'
// MAX    | register signed max lane of row s'
// TARGET | register t = sat16(r + (m*gamma)>>>8)
// WRITE  | commit sat16(q + ((t-q)>>>alpha)) into lane a of row s
// DONE   | retire; done pulse follows one cycle later
module q_update_engine #(
    parameter int          STATE_W     = 4,
    parameter int          ALPHA_SHIFT = 2,
    parameter logic [15:0] GAMMA       = 16'h00E6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [3:0]         action,
    input  logic [15:0]        reward,
    input  logic [STATE_W-1:0] next_state,
    input  logic [STATE_W-1:0] rd_state,
    output logic [63:0]        q_values,
    output logic [15:0]        q_new,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int DEPTH = 1 << STATE_W;

    typedef enum logic [2:0] {IDLE, FETCH, MAX, TARGET, WRITE, DONE} state_t;

    function automatic logic [15:0] sat16(input logic signed [32:0] v);
        if (v > 33'sd32767)
            return 16'h7FFF;
        else if (v < -33'sd32768)
            return 16'h8000;
        else
            return v[15:0];
    endfunction

    function automatic logic [15:0] smax(input logic signed [15:0] a, input logic signed [15:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t              state;
    logic [63:0]         q_table [DEPTH];
    logic [STATE_W-1:0]  s_lat;
    logic [STATE_W-1:0]  sn_lat;
    logic [1:0]          a_lat;
    logic [15:0]         r_lat;
    logic [63:0]         row_cur;
    logic [63:0]         row_next;
    logic [15:0]         m_reg;
    logic [15:0]         t_reg;
    logic                err_pend;

    logic                onehot;
    logic [1:0]          act_idx;
    logic [15:0]         m_comb;
    logic signed [32:0]  p;
    logic signed [32:0]  g;
    logic signed [32:0]  t_sum;
    logic [15:0]         q_cur;
    logic signed [16:0]  d;
    logic signed [16:0]  step;
    logic signed [32:0]  q_sum;
    logic [15:0]         q_new_c;

    assign onehot = (action != 4'd0) && ((action & (action - 4'd1)) == 4'd0);

    always_comb begin
        act_idx = 2'd0;
        case (action)
            4'b0010: act_idx = 2'd1;
            4'b0100: act_idx = 2'd2;
            4'b1000: act_idx = 2'd3;
            default: act_idx = 2'd0;
        endcase
    end

    assign m_comb = smax(smax(row_next[15:0], row_next[31:16]),
                         smax(row_next[47:32], row_next[63:48]));

    // Gamma is unsigned, so it gets a zero sign bit before the signed multiply.
    assign p     = $signed(m_reg) * $signed({1'b0, GAMMA});
    assign g     = p >>> 8;
    assign t_sum = $signed({{17{r_lat[15]}}, r_lat}) + g;

    assign q_cur   = row_cur[{a_lat, 4'b0000} +: 16];
    assign d       = $signed({t_reg[15], t_reg}) - $signed({q_cur[15], q_cur});
    assign step    = d >>> ALPHA_SHIFT;
    assign q_sum   = $signed({{17{q_cur[15]}}, q_cur}) + $signed({{16{step[16]}}, step});
    assign q_new_c = sat16(q_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            for (int i = 0; i < DEPTH; i++) q_table[i] <= 64'd0;
            s_lat    <= '0;
            sn_lat   <= '0;
            a_lat    <= 2'd0;
            r_lat    <= 16'd0;
            row_cur  <= 64'd0;
            row_next <= 64'd0;
            m_reg    <= 16'd0;
            t_reg    <= 16'd0;
            err_pend <= 1'b0;
            q_values <= 64'd0;
            q_new    <= 16'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // Read port is independent of the FSM; a same-cycle write returns the old row.
            q_values <= q_table[rd_state];
            busy     <= (state != IDLE);
            done     <= (state == DONE);
            err      <= err_pend;
            err_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (onehot) begin
                            s_lat  <= cur_state;
                            sn_lat <= next_state;
                            a_lat  <= act_idx;
                            r_lat  <= reward;
                            state  <= FETCH;
                        end else begin
                            err_pend <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    row_cur  <= q_table[s_lat];
                    row_next <= q_table[sn_lat];
                    state    <= MAX;
                end
                MAX: begin
                    m_reg <= m_comb;
                    state <= TARGET;
                end
                TARGET: begin
                    t_reg <= sat16(t_sum);
                    state <= WRITE;
                end
                WRITE: begin
                    q_table[s_lat][{a_lat, 4'b0000} +: 16] <= q_new_c;
                    q_new <= q_new_c;
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
